// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM copy/fill master for a single-port 32-bit on-chip memory slave.
// Accepts one command at a time and issues one word access per bus cycle.
module onchip_mem_copy_master #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  logic                r_mode;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W-1:0]   r_count;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_cs;
  logic                r_wr;
  logic [3:0]          r_be;
  logic [DATA_W-1:0]   r_wdata;

  logic [ADDR_W:0]     w_dst_end;
  logic [ADDR_W:0]     w_src_end;
  logic                w_reject;
  logic [ADDR_W-1:0]   w_src_inc;
  logic [ADDR_W-1:0]   w_dst_inc;

  // One extra bit so that an end address past the top of the space cannot wrap into range.
  assign w_dst_end = {1'b0, dst_addr} + {1'b0, length};
  assign w_src_end = {1'b0, src_addr} + {1'b0, length};
  assign w_reject  = (w_dst_end > LP_DEPTH) || (mode && (w_src_end > LP_DEPTH));
  assign w_src_inc = r_src + ADDR_W'(1);
  assign w_dst_inc = r_dst + ADDR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_addr  <= '0;
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_be    <= 4'hF;
      r_wdata <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_be    <= 4'hF;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_reject) begin
              r_error <= 1'b1;
            end else if (length == '0) begin
              r_done <= 1'b1;
            end else begin
              r_mode  <= mode;
              r_src   <= src_addr;
              r_dst   <= dst_addr;
              r_count <= length;
              r_busy  <= 1'b1;
              r_cs    <= 1'b1;
              if (mode) begin
                r_state <= S_RD;
                r_addr  <= src_addr;
                r_wr    <= 1'b0;
              end else begin
                r_state <= S_WR;
                r_addr  <= dst_addr;
                r_wr    <= 1'b1;
                r_wdata <= fill_value;
              end
            end
          end
        end
        S_RD: begin
          r_state <= S_CAP;
          r_cs    <= 1'b0;
        end
        S_CAP: begin
          // The write-data register doubles as the copy holding register.
          r_wdata <= mem_readdata;
          r_state <= S_WR;
          r_cs    <= 1'b1;
          r_wr    <= 1'b1;
          r_addr  <= r_dst;
        end
        S_WR: begin
          r_src   <= w_src_inc;
          r_dst   <= w_dst_inc;
          r_count <= r_count - ADDR_W'(1);
          if (r_count == ADDR_W'(1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cs    <= 1'b0;
            r_wr    <= 1'b0;
          end else if (r_mode) begin
            r_state <= S_RD;
            r_addr  <= w_src_inc;
            r_wr    <= 1'b0;
          end else begin
            r_state <= S_WR;
            r_addr  <= w_dst_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign mem_address    = r_addr;
  assign mem_chipselect = r_cs;
  assign mem_write      = r_wr;
  assign mem_byteenable = r_be;
  assign mem_writedata  = r_wdata;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Self-checking bench for onchip_mem_copy_master: table of commands with
// hand-computed timing/bus patterns, plus overlap, busy-restart and reset sequences.
module tb_onchip_mem_copy_master;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 10024;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] length;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic              mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] fill;
    int                poke;
    int                exp_err;
    int                exp_done;
    logic [31:0]       exp_rd;
    logic [31:0]       exp_wr;
  } vec_t;

  typedef struct {
    int          ecyc;
    int          dcyc;
    int          nbusy;
    int          bad;
    logic [31:0] rd_mask;
    logic [31:0] wr_mask;
  } res_t;

  onchip_mem_copy_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .mode          (mode),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .length        (length),
    .fill_value    (fill_value),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .mem_address   (mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_byteenable(mem_byteenable),
    .mem_writedata (mem_writedata),
    .mem_clken     (mem_clken),
    .mem_readdata  (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: one-cycle read latency, no waitrequest.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else           mem_readdata     <= mem[mem_address];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issues a command at a negedge; cycle 0 ends at the next posedge. Returns at the
  // negedge of the done/error cycle so a following command starts in that cycle.
  task automatic run_cmd(input vec_t v, output res_t r);
    r.ecyc = -1; r.dcyc = -1; r.nbusy = 0; r.bad = 0;
    r.rd_mask = '0; r.wr_mask = '0;
    mode = v.mode; src_addr = v.src; dst_addr = v.dst; length = v.len; fill_value = v.fill;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (busy) r.nbusy++;
      if (mem_write && !mem_chipselect) r.bad++;
      if (mem_chipselect && mem_byteenable != 4'hF) r.bad++;
      if (mem_chipselect && c < 32) begin
        if (mem_write) r.wr_mask[c] = 1'b1;
        else           r.rd_mask[c] = 1'b1;
      end
      if (c == v.poke) begin
        start = 1'b1; mode = 1'b0; dst_addr = 14'h400; length = 14'd1; fill_value = 32'hBEEF;
      end
      if (c == v.poke + 1) start = 1'b0;
      if (done)  begin r.dcyc = c; break; end
      if (error) begin r.ecyc = c; break; end
    end
    start = 1'b0;
  endtask

  vec_t vecs [14];
  res_t res;
  vec_t v;

  initial begin
    reset_n = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;

    //            mode  src       dst       len     fill          poke err done rd_mask  wr_mask
    vecs[0]  = '{1'b0, 14'h0,    14'h100,  14'd4,  32'hA5A50000, 0,   -1,  5,   32'h0,   32'h1E};
    vecs[1]  = '{1'b0, 14'h0,    14'h000,  14'd1,  32'h11,       0,   -1,  2,   32'h0,   32'h2};
    vecs[2]  = '{1'b0, 14'h0,    14'h001,  14'd1,  32'h22,       0,   -1,  2,   32'h0,   32'h2};
    vecs[3]  = '{1'b0, 14'h0,    14'h002,  14'd1,  32'h33,       0,   -1,  2,   32'h0,   32'h2};
    vecs[4]  = '{1'b1, 14'h0,    14'h200,  14'd3,  32'h0,        0,   -1,  10,  32'h92,  32'h248};
    vecs[5]  = '{1'b0, 14'h0,    14'd10020,14'd5,  32'h1,        0,   1,   -1,  32'h0,   32'h0};
    vecs[6]  = '{1'b0, 14'h0,    14'd10020,14'd4,  32'hCAFE0000, 0,   -1,  5,   32'h0,   32'h1E};
    vecs[7]  = '{1'b0, 14'h0,    14'h005,  14'd0,  32'h9,        0,   -1,  1,   32'h0,   32'h0};
    vecs[8]  = '{1'b1, 14'd10023,14'h000,  14'd2,  32'h0,        0,   1,   -1,  32'h0,   32'h0};
    vecs[9]  = '{1'b0, 14'h0,    14'h400,  14'd1,  32'hDEAD,     0,   -1,  2,   32'h0,   32'h2};
    vecs[10] = '{1'b1, 14'h0,    14'h300,  14'd3,  32'h0,        4,   -1,  10,  32'h92,  32'h248};
    vecs[11] = '{1'b0, 14'h0,    14'h000,  14'd1,  32'h77,       0,   -1,  2,   32'h0,   32'h2};
    vecs[12] = '{1'b1, 14'h0,    14'h001,  14'd3,  32'h0,        0,   -1,  10,  32'h92,  32'h248};
    vecs[13] = '{1'b0, 14'h0,    14'h500,  14'd4,  32'h0BAD,     0,   -1,  5,   32'h0,   32'h1E};

    #3 reset_n = 1'b0;
    #1 check("reset_outputs",
             64'({busy, done, error, mem_chipselect, mem_write, mem_address, mem_writedata, mem_byteenable, mem_clken}),
             64'({5'b0, 14'h0, 32'h0, 4'hF, 1'b1}));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_cmd(vecs[i], res);
      check($sformatf("v%0d_error_cycle", i), 64'(res.ecyc), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_done_cycle", i),  64'(res.dcyc), 64'(vecs[i].exp_done));
      check($sformatf("v%0d_busy_cycles", i), 64'(res.nbusy),
            64'((vecs[i].exp_done > 0) ? vecs[i].exp_done - 1 : 0));
      check($sformatf("v%0d_read_cycles", i),  64'(res.rd_mask), 64'(vecs[i].exp_rd));
      check($sformatf("v%0d_write_cycles", i), 64'(res.wr_mask), 64'(vecs[i].exp_wr));
      check($sformatf("v%0d_bus_rules", i),    64'(res.bad), 64'(0));
    end

    check("mem_fill_100",  64'(mem[14'h100]), 64'(32'hA5A50000));
    check("mem_fill_103",  64'(mem[14'h103]), 64'(32'hA5A50000));
    check("mem_copy_200",  64'(mem[14'h200]), 64'(32'h11));
    check("mem_copy_201",  64'(mem[14'h201]), 64'(32'h22));
    check("mem_copy_202",  64'(mem[14'h202]), 64'(32'h33));
    check("mem_top_10020", 64'(mem[14'd10020]), 64'(32'hCAFE0000));
    check("mem_top_10023", 64'(mem[14'd10023]), 64'(32'hCAFE0000));
    check("mem_copy_302",  64'(mem[14'h302]), 64'(32'h33));
    check("mem_poke_ignored", 64'(mem[14'h400]), 64'(32'hDEAD));
    check("mem_overlap_1", 64'(mem[14'h001]), 64'(32'h77));
    check("mem_overlap_2", 64'(mem[14'h002]), 64'(32'h77));
    check("mem_overlap_3", 64'(mem[14'h003]), 64'(32'h77));

    // Reset in cycle 5 of a 4-word copy: word 0 lands, word 1 must not.
    mode = 1'b1; src_addr = 14'h100; dst_addr = 14'h500; length = 14'd4; fill_value = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pre_read", 64'({mem_chipselect, mem_write, mem_address}), 64'({1'b1, 1'b0, 14'h101}));
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("rst_mid_outputs",
             64'({busy, done, error, mem_chipselect, mem_write, mem_address, mem_writedata, mem_byteenable, mem_clken}),
             64'({5'b0, 14'h0, 32'h0, 4'hF, 1'b1}));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_word0_written", 64'(mem[14'h500]), 64'(32'hA5A50000));
    check("rst_word1_kept",    64'(mem[14'h501]), 64'(32'h0BAD));

    v = '{1'b0, 14'h0, 14'h600, 14'd2, 32'h5, 0, -1, 3, 32'h0, 32'h6};
    run_cmd(v, res);
    check("post_rst_done_cycle",  64'(res.dcyc), 64'(3));
    check("post_rst_write_cycles", 64'(res.wr_mask), 64'(32'h6));
    check("post_rst_mem_601",     64'(mem[14'h601]), 64'(32'h5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onchip_mem_copy_master.md
# onchip_mem_copy_master

Avalon-MM master that drives the single-port 32-bit on-chip memory slave: a memory-to-memory copy and fill engine. It sits between a control source (Nios II PIO or a local FSM) and the memory's s1 port. It takes one command at a time and issues word-wide read and write transactions. Timing matches the slave: one-cycle read latency, no waitrequest. It reports completion or range errors with single-cycle pulses.

## Interface
Parameters:
- ADDR_W, 14, word address width of the memory slave
- DATA_W, 32, data width
- DEPTH, 10024, number of valid words; addresses at or above DEPTH are out of range

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled on rising clk edge while idle
- mode  in  1  0 = fill, 1 = copy
- src_addr  in  ADDR_W  copy source word address (ignored in fill)
- dst_addr  in  ADDR_W  destination word address
- length  in  ADDR_W  word count, 0..DEPTH
- fill_value  in  DATA_W  word written in fill mode
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle rejected-command pulse
- mem_address  out  ADDR_W  to slave address
- mem_chipselect  out  1  to slave chipselect
- mem_write  out  1  to slave write
- mem_byteenable  out  4  to slave byteenable
- mem_writedata  out  DATA_W  to slave writedata
- mem_clken  out  1  to slave clken, constant 1
- mem_readdata  in  DATA_W  from slave readdata, valid the cycle after a read address is presented

## Operation
- States: IDLE, RD, CAP, WR.
  - Fill uses IDLE→WR→…→IDLE.
  - Copy cycles RD→CAP→WR per word.
- Command latch: in IDLE, start=1 latches mode, addresses, length and fill_value.
  - start while busy is ignored. Inputs are not re-sampled during a command.
- Range check at acceptance (ADDR_W+1-bit arithmetic, no wrap):
  - Reject if dst_addr+length > DEPTH.
  - In copy mode, also reject if src_addr+length > DEPTH.
  - On reject: error=1 for one cycle, no bus access, stay IDLE.
- length=0 in range: done=1 the next cycle, no bus access.
- RD: mem_chipselect=1, mem_write=0, mem_address=src pointer.
- CAP: bus idle (chipselect=0). mem_readdata is registered into a data holding register.
- WR: mem_chipselect=1, mem_write=1, mem_address=dst pointer.
  - mem_writedata is fill_value (fill) or the holding register (copy).
  - Both pointers increment by 1 and the remaining count decrements.
  - Count reaching 0 → IDLE with done pulse. Otherwise → WR (fill) or RD (copy).
- Addresses ascend only. Overlapping copy is defined by word order: each word is read immediately before its own write. With dst in (src, src+length), earlier written words propagate forward.
- mem_byteenable is 4'hF on every access. All mem_* outputs except mem_clken are registered.
- reset_n low, at any time including mid-command:
  - state → IDLE; busy, done, error, mem_chipselect, mem_write = 0.
  - mem_address, mem_writedata = 0; mem_byteenable = 4'hF; mem_clken = 1.
  - No partial write is completed.

## Timing
- Cycle 0 is the cycle in which start is sampled high.
- busy=1 from cycle 1 through the last bus cycle. It is low in the done cycle.
- Fill of L words:
  - Word i is written in cycle 1+i.
  - done pulses in cycle L+1.
- Copy of L words:
  - Word i: read in cycle 1+3i, captured in cycle 2+3i, written in cycle 3+3i.
  - done pulses in cycle 3L+1.
- error pulses in cycle 1. busy stays 0.
- start=1 in the done or error cycle is accepted; a new command's cycle 0 may coincide with the pulse.
- Never more than one access per cycle. mem_write is never asserted without mem_chipselect.

## Test plan
- Fill dst=0x0100, L=4, value 0xA5A5_0000 → writes to 0x100..0x103 in cycles 1..4, done in cycle 5. Readback through the slave model matches.
- Preload 0x0000..0x0002 = 0x11,0x22,0x33; copy src=0, dst=0x0200, L=3 → read/write pattern at cycles 1/3, 4/6, 7/9, done in cycle 10, 0x200..0x202 = 0x11,0x22,0x33.
- Copy src=0, dst=1, L=3 with mem[0]=0x77 → mem[1..3] all 0x77 (forward overlap).
- Fill dst=10020, L=5 → error in cycle 1, no chipselect ever, busy 0. Then fill dst=10020, L=4 is accepted and the last address written is 10023.
- L=0 → done in cycle 1, no bus access. start pulsed while busy mid-copy → ignored, original done timing unchanged.
- reset_n low in cycle 5 of a 4-word copy → all outputs immediately at reset values. After release the next start runs normally.
